// File: rtl/aes_enc_add_round_key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_enc_add_round_key_pkg
// Description : Shared AES-128 encrypt definitions. Provides the round count,
//               the FSM state encoding, the forward S-box (the same table
//               used by SubBytes) and the key-schedule Rcon table.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_enc_add_round_key_pkg;

    // Number of AES-128 rounds; round index runs 0..NR.
    localparam int NR = 10;
    localparam logic [3:0] c_LAST_ROUND = 4'(NR);

    typedef enum logic [0:0] {
        ST_NOKEY = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [7:0] c_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return c_SBOX[x];
    endfunction

    // Rcon for key-expansion step idx (1..NR); 0 outside that range.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_enc_add_round_key_key_sched_step.sv
`default_nettype none
// ============================================================================
// Module      : aes_enc_add_round_key_key_sched_step
// Description : One combinational AES-128 key-expansion step. Derives the
//               next round key from the current one and its Rcon byte.
// Ports       : i_roundKey [127:0] current round key (w0 in [127:96])
//               i_rcon     [7:0]   round constant for the step
//               o_nextKey  [127:0] next round key
// Revision    : 1.0 - initial release
// ============================================================================
module aes_enc_add_round_key_key_sched_step
    import aes_enc_add_round_key_pkg::*;
(
    input  logic [127:0] i_roundKey,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_nextKey
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rotWord;
    logic [31:0] w_subWord;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0 = i_roundKey[127:96];
    assign w_w1 = i_roundKey[95:64];
    assign w_w2 = i_roundKey[63:32];
    assign w_w3 = i_roundKey[31:0];

    // RotWord: cyclic left rotate by one byte.
    assign w_rotWord = {w_w3[23:0], w_w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subWord
        assign w_subWord[8*b +: 8] = sbox(w_rotWord[8*b +: 8]);
    end

    assign w_n0 = w_w0 ^ w_subWord ^ {i_rcon, 24'h000000};
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_nextKey = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/aes_enc_add_round_key.sv
`default_nettype none
// ============================================================================
// Module      : aes_enc_add_round_key
// Description : Iterative AES-128 AddRoundKey stage. XORs each accepted state
//               with the current round key into a single registered output
//               slot, expanding the round key one step per accepted beat.
// Ports       : Clk, Rst           clock, synchronous active-high reset
//               KeyLoad, KeyIn     load cipher key, restart key schedule
//               InValid/InReady    input handshake, DataIn [127:0]
//               OutValid/OutReady  output handshake, DataOut [127:0]
//               RoundOut [3:0]     round index used for DataOut
//               LastRound          RoundOut == NR
//               Busy               a block is in flight (round 0..NR-1 done)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_enc_add_round_key
    import aes_enc_add_round_key_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst,
    input  logic         KeyLoad,
    input  logic [127:0] KeyIn,
    input  logic         InValid,
    output logic         InReady,
    input  logic [127:0] DataIn,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [127:0] DataOut,
    output logic [3:0]   RoundOut,
    output logic         LastRound,
    output logic         Busy
);

    state_t        r_state;
    logic [127:0]  r_cipherKey;
    logic [127:0]  r_roundKey;
    logic [3:0]    r_round;
    logic          r_outValid;
    logic [127:0]  r_dataOut;
    logic [3:0]    r_roundOut;
    logic          r_lastRound;
    logic          r_busy;

    logic [127:0]  w_nextKey;
    logic [3:0]    w_nextRound;
    logic          w_isLast;
    logic          w_inReady;
    logic          w_accept;

    assign w_nextRound = r_round + 4'd1;
    assign w_isLast    = (r_round == c_LAST_ROUND);

    aes_enc_add_round_key_key_sched_step u_keySchedStep (
        .i_roundKey (r_roundKey),
        .i_rcon     (rcon(w_nextRound)),
        .o_nextKey  (w_nextKey)
    );

    // KeyLoad and Rst both pre-empt a beat, so the producer must not see
    // ready in those cycles.
    assign w_inReady = (r_state == ST_RUN) && !Rst && !KeyLoad &&
                       (!r_outValid || OutReady);
    assign w_accept  = InValid && w_inReady;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= ST_NOKEY;
            r_cipherKey <= '0;
            r_roundKey  <= '0;
            r_round     <= '0;
            r_outValid  <= 1'b0;
            r_dataOut   <= '0;
            r_roundOut  <= '0;
            r_lastRound <= 1'b0;
            r_busy      <= 1'b0;
        end else if (KeyLoad) begin
            r_state     <= ST_RUN;
            r_cipherKey <= KeyIn;
            r_roundKey  <= KeyIn;
            r_round     <= '0;
            r_outValid  <= 1'b0;
            r_busy      <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (w_accept) begin
                r_dataOut   <= DataIn ^ r_roundKey;
                r_roundOut  <= r_round;
                r_lastRound <= w_isLast;
                r_outValid  <= 1'b1;
                if (w_isLast) begin
                    // Rewind so the next block runs without a reload.
                    r_roundKey <= r_cipherKey;
                    r_round    <= '0;
                    r_busy     <= 1'b0;
                end else begin
                    r_roundKey <= w_nextKey;
                    r_round    <= w_nextRound;
                    if (r_round == 4'd0) begin
                        r_busy <= 1'b1;
                    end
                end
            end else if (OutReady) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign InReady   = w_inReady;
    assign OutValid  = r_outValid;
    assign DataOut   = r_dataOut;
    assign RoundOut  = r_roundOut;
    assign LastRound = r_lastRound;
    assign Busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_add_round_key.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_enc_add_round_key
// Description : Directed self-checking bench for aes_enc_add_round_key using
//               FIPS-197 vectors and hand-computed XOR results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_enc_add_round_key;
    import aes_enc_add_round_key_pkg::*;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         KeyLoad;
    logic [127:0] KeyIn;
    logic         InValid;
    logic         InReady;
    logic [127:0] DataIn;
    logic         OutValid;
    logic         OutReady;
    logic [127:0] DataOut;
    logic [3:0]   RoundOut;
    logic         LastRound;
    logic         Busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] c_K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_EX1 = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] c_K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

    localparam logic [127:0] c_RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    aes_enc_add_round_key dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .KeyLoad   (KeyLoad),
        .KeyIn     (KeyIn),
        .InValid   (InValid),
        .InReady   (InReady),
        .DataIn    (DataIn),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .DataOut   (DataOut),
        .RoundOut  (RoundOut),
        .LastRound (LastRound),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // External round stages, used only to build DataIn for the FIPS block.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] subBytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shiftRows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    initial begin
        logic [127:0] st;
        logic [127:0] din;

        Rst = 1'b1; KeyLoad = 1'b0; KeyIn = '0;
        InValid = 1'b0; DataIn = '0; OutReady = 1'b1;
        tick(); tick();
        check("rst_outvalid",  128'(OutValid),  128'd0);
        check("rst_dataout",   DataOut,         128'd0);
        check("rst_roundout",  128'(RoundOut),  128'd0);
        check("rst_lastround", 128'(LastRound), 128'd0);
        check("rst_busy",      128'(Busy),      128'd0);
        Rst = 1'b0;
        #1;
        check("nokey_inready", 128'(InReady), 128'd0);

        // No key held: input is ignored.
        InValid = 1'b1; DataIn = c_PT1;
        tick();
        check("nokey_ignored", 128'(OutValid), 128'd0);

        // Single round-0 beat with the sequential key.
        InValid = 1'b0; KeyLoad = 1'b1; KeyIn = c_K1;
        tick();
        KeyLoad = 1'b0; InValid = 1'b1; DataIn = c_PT1;
        #1;
        check("t1_inready", 128'(InReady), 128'd1);
        tick();
        InValid = 1'b0;
        check("t1_outvalid", 128'(OutValid), 128'd1);
        check("t1_data",     DataOut,        c_EX1);
        check("t1_round",    128'(RoundOut), 128'd0);
        check("t1_busy",     128'(Busy),     128'd1);
        tick();
        check("t1_drained",  128'(OutValid), 128'd0);

        // Zero data streamed back-to-back exposes every round key.
        KeyLoad = 1'b1; KeyIn = c_K2;
        tick();
        KeyLoad = 1'b0;
        check("reload_busy", 128'(Busy), 128'd0);
        InValid = 1'b1; DataIn = '0;
        for (int i = 0; i <= 10; i++) begin
            tick();
            check("t2_valid", 128'(OutValid),  128'd1);
            check("t2_rk",    DataOut,         c_RK[i]);
            check("t2_round", 128'(RoundOut),  128'(i));
            check("t2_last",  128'(LastRound), 128'(i == 10));
            check("t2_busy",  128'(Busy),      128'(i != 10));
        end
        InValid = 1'b0;
        tick();
        check("t2_idle", 128'(OutValid), 128'd0);

        // Full FIPS-197 block, twice without a key reload.
        for (int b = 0; b < 2; b++) begin
            st = '0;
            for (int r = 0; r <= 10; r++) begin
                if (r == 0)      din = c_PT2;
                else if (r < 10) din = mixColumns(shiftRows(subBytes(st)));
                else             din = shiftRows(subBytes(st));
                DataIn = din; InValid = 1'b1;
                tick();
                st = din ^ c_RK[r];
                check("fips_round", 128'(RoundOut), 128'(r));
                check("fips_state", DataOut, st);
            end
            check("fips_ct",   DataOut,         c_CT2);
            check("fips_last", 128'(LastRound), 128'd1);
        end
        InValid = 1'b0;
        tick();

        // Backpressure for three cycles after round 3.
        InValid = 1'b1; DataIn = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_pre", DataOut, c_RK[i]);
        end
        OutReady = 1'b0;
        #1;
        check("bp_inready_lo", 128'(InReady), 128'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_data",  DataOut,         c_RK[3]);
            check("bp_hold_round", 128'(RoundOut),  128'd3);
            check("bp_hold_valid", 128'(OutValid),  128'd1);
            check("bp_inready",    128'(InReady),   128'd0);
        end
        OutReady = 1'b1;
        #1;
        check("bp_inready_hi", 128'(InReady), 128'd1);
        for (int i = 4; i <= 10; i++) begin
            tick();
            check("bp_post",       DataOut,        c_RK[i]);
            check("bp_post_round", 128'(RoundOut), 128'(i));
        end
        InValid = 1'b0;
        tick();

        // KeyLoad at round 5 with a beat offered.
        InValid = 1'b1; DataIn = '0;
        for (int i = 0; i < 5; i++) tick();
        KeyLoad = 1'b1; KeyIn = c_K1;
        #1;
        check("kl_inready", 128'(InReady), 128'd0);
        tick();
        KeyLoad = 1'b0;
        check("kl_outvalid", 128'(OutValid), 128'd0);
        check("kl_busy",     128'(Busy),     128'd0);
        DataIn = c_PT1;
        tick();
        check("kl_round", 128'(RoundOut), 128'd0);
        check("kl_data",  DataOut,        c_EX1);
        InValid = 1'b0;
        tick();

        // Reset at round 7, asserted together with KeyLoad.
        KeyLoad = 1'b1; KeyIn = c_K2;
        tick();
        KeyLoad = 1'b0; InValid = 1'b1; DataIn = '0;
        for (int i = 0; i < 7; i++) tick();
        check("pre_rst_round", 128'(RoundOut), 128'd6);
        Rst = 1'b1; KeyLoad = 1'b1;
        tick();
        Rst = 1'b0; KeyLoad = 1'b0;
        #1;
        check("rst7_outvalid",  128'(OutValid),  128'd0);
        check("rst7_dataout",   DataOut,         128'd0);
        check("rst7_roundout",  128'(RoundOut),  128'd0);
        check("rst7_lastround", 128'(LastRound), 128'd0);
        check("rst7_busy",      128'(Busy),      128'd0);
        check("rst7_inready",   128'(InReady),   128'd0);
        tick();
        check("rst7_ignored", 128'(OutValid), 128'd0);
        InValid = 1'b0; KeyLoad = 1'b1; KeyIn = c_K2;
        tick();
        KeyLoad = 1'b0; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        check("rst7_restart_data", DataOut,    c_RK[0]);
        check("rst7_restart_busy", 128'(Busy), 128'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
